demux_rr_arbiter: RTL

DEMUX_RR_ARBITER -- requirements
Module: demux_rr_arbiter

---
 rtl/demux_arb_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 27 ++
 rtl/demux_rr_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/demux_arb_pkg.sv
// Shared types and constants for the round-robin demux arbiter.
package demux_arb_pkg;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority pick: first set request at or after ptr, wrapping 3->0.
module rr_priority_pick
  import demux_arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             vld
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        win = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_arbiter.sv
// Round-robin owner of a 1-to-4 demux with hold limit and a one-cycle
// break-before-make gap between owners. All outputs come from flops.
module demux_rr_arbiter
  import demux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic             done,
  output logic             S1,
  output logic             S0,
  output logic             En,
  output logic [REQ_N-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0]       HOLD_CNT  = 8'(HOLD_MAX);
  localparam logic [REQ_N-1:0] GRANT_ONE = REQ_N'(1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [REQ_N-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;

  logic [SEL_W-1:0] pick_win;
  logic             pick_vld;
  logic             hold_hit;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .vld (pick_vld)
  );

  assign hold_hit = (cnt_q == HOLD_CNT);

  // Next-state and registered-output logic; IDLE and GAP arbitrate identically.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    grant_d = grant_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_vld) begin
          state_d = ST_OWN;
          en_d    = 1'b1;
          sel_d   = pick_win;
          grant_d = GRANT_ONE << pick_win;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (done || !req[sel_q] || hold_hit) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
          // Only a forced revoke pulses timeout; a voluntary release wins ties.
          to_d    = hold_hit && !done && req[sel_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign S1      = sel_q[1];
  assign S0      = sel_q[0];
  assign En      = en_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule
